fir_load_ctrl: RTL and testbench
================================

FIR_LOAD_CTRL -- requirements
Module: fir_load_ctrl

Interface
REQ-001 SHALL have parameter TAPS, default 127, meaning the FIR tap count; NCOEF = TAPS/2+1 unique coefficients.
REQ-002 SHALL have parameter AW, default $clog2(TAPS/2+1), meaning the FIR coefficient address width; NCOEF <= 128 is required.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is posedge clk.
REQ-005 SHALL have port reset, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port csr_address, input, 8: the CSR word address; 0x00..NCOEF-1 are shadow coefficients, 0x80 CTRL, 0x81 STATUS, 0x82 DIV, 0x83 COUNT.
REQ-007 SHALL have ports csr_write (input, 1), csr_writedata (input, 32), csr_read (input, 1) and csr_readdata (output, 32).
REQ-008 SHALL have ports fir_reset (output, 1), fir_write (output, 1), fir_addr (output, AW) and fir_wdata (output, 32), which drive the FIR reset and write ports.
REQ-009 SHALL have port smplvalid, output, 1: the sample strobe to the FIR.
REQ-010 SHALL have ports busy (output, 1), high when not IDLE, and irq (output, 1), a one-cycle load-complete pulse.

Function
REQ-011 SHALL store csr_writedata into shadow[csr_address] on a csr_write to an address below NCOEF while IDLE; writes to unmapped addresses are ignored.
REQ-012 SHALL return csr_readdata one cycle after csr_read, holding its value otherwise: shadow word; STATUS {29'b0, err, done, busy}; DIV[15:0] zero-extended; COUNT[15:0] zero-extended; CTRL and unmapped addresses read 0.
REQ-013 SHALL start a load on a CTRL write with bit0=1 while IDLE; writing CTRL bit1=1 clears done and err.
REQ-014 SHALL ignore a commit or shadow write that arrives while busy, and shall set the sticky err bit instead.
REQ-015 SHALL perform only the clear when CTRL bit0 and bit1 are written together while IDLE; no load starts.
REQ-016 SHALL implement the FSM IDLE -> FLUSH -> LOAD -> SETTLE -> IDLE.
REQ-017 SHALL spend exactly 1 cycle in FLUSH with fir_reset=1.
REQ-018 SHALL spend exactly NCOEF cycles in LOAD: fir_write=1, fir_addr=i, fir_wdata=shadow[i], for i = 0..NCOEF-1 in consecutive cycles, with fir_reset=1.
REQ-019 SHALL spend exactly 2 cycles in SETTLE with fir_reset=1, then return to IDLE.
REQ-020 SHALL, on the SETTLE->IDLE transition, pulse irq for one cycle, set done and increment COUNT, with COUNT wrapping 0xFFFF -> 0.
REQ-021 SHALL make the commit-to-IDLE latency exactly NCOEF+3 cycles after the CTRL write cycle, with busy asserted from the cycle after that write.
REQ-022 SHALL hold fir_reset=0 in IDLE.
REQ-023 SHALL hold fir_write=0, fir_addr=0 and fir_wdata=0 outside LOAD.
REQ-024 SHALL, in IDLE with DIV!=0, run a 16-bit divider counting 0..DIV-1 and pulse smplvalid when the count equals DIV-1, so the strobe period is DIV cycles.
REQ-025 SHALL keep smplvalid=0 when DIV=0.
REQ-026 SHALL force smplvalid=0 and hold the divider count at 0 whenever not IDLE; the first strobe after a load occurs DIV cycles after IDLE re-entry.
REQ-027 SHALL reset the divider count to 0 on a DIV write.
REQ-028 SHALL make a DIV write while busy take effect (DIV is not a protected register).
REQ-029 SHALL set done (and increment COUNT) when irq coincides with a CTRL clear in the same cycle; the clear is overridden.

Reset
REQ-030 SHALL, on reset assertion and asynchronously, force: FSM to IDLE; fir_reset, fir_write, smplvalid, busy and irq to 0; fir_addr and fir_wdata to 0; csr_readdata to 0; done and err to 0; COUNT to 0; DIV to 0; divider count to 0.
REQ-031 SHALL leave shadow contents undefined after reset (no reset on the array).
REQ-032 SHALL, on reset mid-load, abandon the load with no irq; fir_reset drops with reset and the FIR holds partial coefficients until the next commit.

Verification
REQ-033 SHALL be verified by: NCOEF=64, write shadow[i]=i+0x100, commit -> fir_reset high for 67 cycles; 64 consecutive fir_write with addr 0..63 and data 0x100..0x13F; irq one cycle; STATUS=0x2; COUNT=1.
REQ-034 SHALL be verified by: DIV=4 in IDLE -> smplvalid every 4th cycle; commit -> no strobe while busy; first strobe 4 cycles after IDLE re-entry.
REQ-035 SHALL be verified by: commit, then at LOAD cycle 10 write shadow[3]=0xDEAD and a second commit -> both ignored; err=1; COUNT=1; shadow[3] unchanged on readback.
REQ-036 SHALL be verified by: reset asserted at LOAD cycle 20 -> all outputs 0 asynchronously; no irq; COUNT=0; DIV=0; subsequent commit loads all 64 words.
REQ-037 SHALL be verified by: CTRL=0x3 in IDLE with done=1 and err=1 -> STATUS reads 0 and no load starts; read of 0x90 -> 0; write of 0x40 ignored.
REQ-038 SHALL be verified by: COUNT preset to 0xFFFF by 65535 loads (or a forced value) -> the next load wraps COUNT to 0 with irq still pulsing.

Source files
------------

// File: rtl/fir_load_ctrl_if.sv
// CSR bus between a host and the FIR coefficient load controller.
// The host is the master; fir_load_ctrl is the slave.
interface fir_load_ctrl_if;
   logic [7:0]  csr_address;
   logic        csr_write;
   logic [31:0] csr_writedata;
   logic        csr_read;
   logic [31:0] csr_readdata;

   modport master (
      output csr_address, csr_write, csr_writedata, csr_read,
      input  csr_readdata
   );
   modport slave (
      input  csr_address, csr_write, csr_writedata, csr_read,
      output csr_readdata
   );
endinterface

// File: rtl/fir_load_ctrl.sv
// Shadowed FIR coefficient loader with a CSR front end and a sample-strobe divider.
//   state    | meaning
//   IDLE     | shadow writable, divider running, FIR out of reset
//   FLUSH    | one cycle of FIR reset before coefficients stream out
//   LOAD     | one shadow word per cycle to the FIR, address 0..NCOEF-1
//   SETTLE   | two cycles of FIR reset after the last word, then irq
module fir_load_ctrl #(
   parameter int TAPS = 127,
   parameter int AW   = $clog2(TAPS/2+1)
) (
   input  logic           clk,
   input  logic           reset,
   fir_load_ctrl_if.slave csr,
   output logic           fir_reset,
   output logic           fir_write,
   output logic [AW-1:0]  fir_addr,
   output logic [31:0]    fir_wdata,
   output logic           smplvalid,
   output logic           busy,
   output logic           irq
);
   localparam int NCOEF = TAPS/2+1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FLUSH  = 2'd1;
   localparam logic [1:0] S_LOAD   = 2'd2;
   localparam logic [1:0] S_SETTLE = 2'd3;

   localparam logic [7:0] A_CTRL   = 8'h80;
   localparam logic [7:0] A_STATUS = 8'h81;
   localparam logic [7:0] A_DIV    = 8'h82;
   localparam logic [7:0] A_COUNT  = 8'h83;

   logic [1:0]    state;
   logic [AW-1:0] idx;
   logic          settle_cnt;
   logic [31:0]   shadow [NCOEF];
   logic          done, err;
   logic [15:0]   count, div, div_cnt;
   logic          smpl_q;
   logic [31:0]   rd_mux;

   logic idle, coef_hit, ctrl_wr, div_wr, commit, clear, err_set, load_done;

   assign idle      = (state == S_IDLE);
   assign coef_hit  = (csr.csr_address < 8'(NCOEF));
   assign ctrl_wr   = csr.csr_write && (csr.csr_address == A_CTRL);
   assign div_wr    = csr.csr_write && (csr.csr_address == A_DIV);
   assign clear     = ctrl_wr && csr.csr_writedata[1];
   assign commit    = ctrl_wr && csr.csr_writedata[0] && !csr.csr_writedata[1] && idle;
   assign err_set   = !idle && ((csr.csr_write && coef_hit) || (ctrl_wr && csr.csr_writedata[0]));
   assign load_done = (state == S_SETTLE) && settle_cnt;

   assign busy      = !idle;
   assign fir_reset = !idle;
   assign fir_write = (state == S_LOAD);
   assign fir_addr  = fir_write ? idx : '0;
   assign fir_wdata = fir_write ? shadow[idx] : '0;
   assign smplvalid = smpl_q && idle;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         idx        <= '0;
         settle_cnt <= 1'b0;
      end else begin
         case (state)
            S_IDLE:   if (commit) state <= S_FLUSH;
            S_FLUSH: begin
               state <= S_LOAD;
               idx   <= '0;
            end
            S_LOAD: begin
               if (idx == AW'(NCOEF-1)) begin
                  state      <= S_SETTLE;
                  settle_cnt <= 1'b0;
                  idx        <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_SETTLE: begin
               if (settle_cnt) state <= S_IDLE;
               else            settle_cnt <= 1'b1;
            end
            default:  state <= S_IDLE;
         endcase
      end
   end

   // Shadow array is deliberately left without reset so a load can be replayed after one.
   always_ff @(posedge clk) begin
      if (csr.csr_write && idle && coef_hit)
         shadow[csr.csr_address[AW-1:0]] <= csr.csr_writedata;
   end

   // A completing load wins over a same-cycle clear of done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done  <= 1'b0;
         err   <= 1'b0;
         count <= '0;
         irq   <= 1'b0;
      end else begin
         irq <= load_done;
         if (load_done) begin
            done  <= 1'b1;
            count <= count + 16'd1;
         end else if (clear) begin
            done <= 1'b0;
         end
         if (err_set)    err <= 1'b1;
         else if (clear) err <= 1'b0;
      end
   end

   // Registered strobe: first pulse lands DIV cycles after the counter restarts at 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div     <= '0;
         div_cnt <= '0;
         smpl_q  <= 1'b0;
      end else begin
         if (div_wr) div <= csr.csr_writedata[15:0];
         if (div_wr || !idle || (div == 16'd0)) begin
            div_cnt <= '0;
            smpl_q  <= 1'b0;
         end else if (div_cnt == div - 16'd1) begin
            div_cnt <= '0;
            smpl_q  <= 1'b1;
         end else begin
            div_cnt <= div_cnt + 16'd1;
            smpl_q  <= 1'b0;
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      if (coef_hit) begin
         rd_mux = shadow[csr.csr_address[AW-1:0]];
      end else begin
         case (csr.csr_address)
            A_STATUS: rd_mux = {29'b0, err, done, busy};
            A_DIV:    rd_mux = {16'b0, div};
            A_COUNT:  rd_mux = {16'b0, count};
            default:  rd_mux = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)             csr.csr_readdata <= '0;
      else if (csr.csr_read) csr.csr_readdata <= rd_mux;
   end
endmodule

// File: tb/tb_fir_load_ctrl.sv
// Directed bench for fir_load_ctrl (TAPS=127, 64 coefficients); all DUT
// driving and sampling happens on the falling clock edge.
module tb_fir_load_ctrl;
   localparam int NC = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fir_reset, fir_write, smplvalid, busy, irq;
   logic [5:0]  fir_addr;
   logic [31:0] fir_wdata;
   logic [31:0] rd;
   logic [31:0] model [NC];
   int          checks = 0;
   int          errors = 0;

   fir_load_ctrl_if csr_bus ();

   fir_load_ctrl #(.TAPS(127)) dut (
      .clk       (clk),
      .reset     (reset),
      .csr       (csr_bus),
      .fir_reset (fir_reset),
      .fir_write (fir_write),
      .fir_addr  (fir_addr),
      .fir_wdata (fir_wdata),
      .smplvalid (smplvalid),
      .busy      (busy),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
      csr_bus.csr_address   = a;
      csr_bus.csr_writedata = d;
      csr_bus.csr_write     = 1'b1;
      @(negedge clk);
      csr_bus.csr_write     = 1'b0;
   endtask

   task automatic csr_rd(input logic [7:0] a, output logic [31:0] d);
      csr_bus.csr_address = a;
      csr_bus.csr_read    = 1'b1;
      @(negedge clk);
      csr_bus.csr_read    = 1'b0;
      d = csr_bus.csr_readdata;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check_val("idle_timeout", {31'b0, busy}, 32'h0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_outs"},
                {26'b0, fir_reset, fir_write, smplvalid, busy, irq, 1'b0}, 32'h0);
      check_val({tag, "_addr"}, {26'b0, fir_addr}, 32'h0);
      check_val({tag, "_wdata"}, fir_wdata, 32'h0);
   endtask

   // Commit and watch the whole sequence; ends one cycle after IDLE re-entry.
   task automatic run_load(input string tag);
      int n, n_rst, nw, bad, first_w, sv, irq_busy;
      n = 0; n_rst = 0; nw = 0; bad = 0; first_w = -1; sv = 0; irq_busy = 0;
      csr_wr(8'h80, 32'h1);
      while (busy && n < 300) begin
         if (fir_reset) n_rst++;
         if (smplvalid) sv++;
         if (irq) irq_busy++;
         if (fir_write) begin
            if (first_w < 0) first_w = n;
            if (nw >= NC || fir_addr != 6'(nw) || fir_wdata !== model[nw]) bad++;
            nw++;
         end else if (fir_addr != 6'd0 || fir_wdata != 32'd0) begin
            bad++;
         end
         @(negedge clk);
         n++;
      end
      check_val({tag, "_busy_cycles"}, n, 67);
      check_val({tag, "_fir_reset_cycles"}, n_rst, 67);
      check_val({tag, "_write_count"}, nw, NC);
      check_val({tag, "_write_seq_bad"}, bad, 0);
      check_val({tag, "_first_write"}, first_w, 1);
      check_val({tag, "_busy_strobe_irq"}, sv + irq_busy, 0);
      check_val({tag, "_idle_entry"}, {30'b0, irq, fir_reset}, 32'h2);
      @(negedge clk);
      check_val({tag, "_irq_one_cycle"}, {31'b0, irq}, 32'h0);
   endtask

   initial begin
      logic [11:0] vec12;
      logic [3:0]  vec4;
      int          sv;

      csr_bus.csr_address   = '0;
      csr_bus.csr_writedata = '0;
      csr_bus.csr_write     = 1'b0;
      csr_bus.csr_read      = 1'b0;
      for (int i = 0; i < NC; i++) model[i] = 32'h100 + 32'(i);

      repeat (2) @(negedge clk);
      check_outputs_zero("reset");
      check_val("reset_readdata", csr_bus.csr_readdata, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      csr_rd(8'h81, rd); check_val("status_after_reset", rd, 32'h0);
      csr_rd(8'h83, rd); check_val("count_after_reset", rd, 32'h0);

      for (int i = 0; i < NC; i++) csr_wr(8'(i), model[i]);
      csr_rd(8'h05, rd); check_val("shadow5_readback", rd, 32'h105);
      csr_rd(8'h3F, rd); check_val("shadow63_readback", rd, 32'h13F);

      run_load("load1");
      csr_rd(8'h81, rd); check_val("load1_status", rd, 32'h2);
      csr_rd(8'h83, rd); check_val("load1_count", rd, 32'h1);

      // Divider: DIV=4 gives a strobe every 4th cycle, first one 4 cycles after restart.
      csr_wr(8'h82, 32'h4);
      vec12 = '0;
      for (int k = 0; k < 12; k++) begin
         vec12[k] = smplvalid;
         @(negedge clk);
      end
      check_val("div4_pattern", {20'b0, vec12}, 32'h110);
      csr_rd(8'h82, rd); check_val("div_readback", rd, 32'h4);
      run_load("load_div");
      vec4 = '0;
      for (int k = 0; k < 4; k++) begin
         vec4[k] = smplvalid;
         @(negedge clk);
      end
      check_val("div4_after_load", {28'b0, vec4}, 32'h8);
      csr_wr(8'h82, 32'h0);
      sv = 0;
      for (int k = 0; k < 10; k++) begin
         if (smplvalid) sv++;
         @(negedge clk);
      end
      check_val("div0_no_strobe", sv, 0);

      // Writes while busy are dropped and flag err.
      csr_wr(8'h80, 32'h2);
      csr_rd(8'h81, rd); check_val("clear_status", rd, 32'h0);
      csr_wr(8'h80, 32'h1);
      repeat (11) @(negedge clk);
      check_val("load_idx10", {26'b0, fir_addr}, 32'd10);
      csr_wr(8'h03, 32'hDEAD);
      csr_wr(8'h80, 32'h1);
      wait_idle();
      check_val("err_irq", {31'b0, irq}, 32'h1);
      @(negedge clk);
      check_val("err_no_second_load", {31'b0, busy}, 32'h0);
      csr_rd(8'h81, rd); check_val("err_status", rd, 32'h6);
      csr_rd(8'h83, rd); check_val("err_count", rd, 32'h3);
      csr_rd(8'h03, rd); check_val("err_shadow3", rd, 32'h103);

      // Reset in the middle of LOAD.
      csr_wr(8'h82, 32'h4);
      csr_wr(8'h80, 32'h1);
      repeat (21) @(negedge clk);
      check_val("midload_idx20", {25'b0, fir_write, fir_addr}, {25'b0, 1'b1, 6'd20});
      #2 reset = 1'b1;
      #1 check_outputs_zero("async_reset");
      check_val("async_reset_readdata", csr_bus.csr_readdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      sv = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (irq || smplvalid || busy) sv++;
      end
      check_val("post_reset_quiet", sv, 0);
      csr_rd(8'h83, rd); check_val("post_reset_count", rd, 32'h0);
      csr_rd(8'h82, rd); check_val("post_reset_div", rd, 32'h0);
      csr_rd(8'h81, rd); check_val("post_reset_status", rd, 32'h0);
      run_load("reload");
      csr_rd(8'h83, rd); check_val("reload_count", rd, 32'h1);

      // Combined clear+commit only clears; unmapped addresses are inert.
      csr_wr(8'h80, 32'h1);
      csr_wr(8'h00, 32'hBAD);
      wait_idle();
      @(negedge clk);
      csr_rd(8'h81, rd); check_val("pre_clear_status", rd, 32'h6);
      csr_wr(8'h80, 32'h3);
      check_val("clear_no_load_a", {31'b0, busy}, 32'h0);
      @(negedge clk);
      check_val("clear_no_load_b", {30'b0, busy, fir_reset}, 32'h0);
      csr_rd(8'h81, rd); check_val("clear_status2", rd, 32'h0);
      csr_rd(8'h90, rd); check_val("unmapped_90", rd, 32'h0);
      csr_rd(8'h80, rd); check_val("ctrl_reads_zero", rd, 32'h0);
      csr_wr(8'h40, 32'h1234);
      csr_rd(8'h40, rd); check_val("unmapped_40", rd, 32'h0);
      csr_rd(8'h00, rd); check_val("shadow0_intact", rd, 32'h100);

      // COUNT wrap from a forced 0xFFFF.
      force dut.count = 16'hFFFF;
      @(negedge clk);
      release dut.count;
      csr_rd(8'h83, rd); check_val("count_preset", rd, 32'hFFFF);
      run_load("wrap");
      csr_rd(8'h83, rd); check_val("count_wrapped", rd, 32'h0);
      csr_rd(8'h81, rd); check_val("wrap_status", rd, 32'h2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
